// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response codes, len-width helper and FSM state enums
// Contents:
//   RESP_OKAY / RESP_EXOKAY / RESP_SLVERR / RESP_DECERR : 2-bit xRESP codes
//   len_w(protocol) : width of AxLEN (8 for AXI4, 4 for AXI3)
//   w_state_t / r_state_t : write- and read-channel FSM states of the error slave
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // protocol 1 selects AXI3 (4-bit len); anything else is AXI4 (8-bit len)
  function automatic int len_w(input int protocol);
    return (protocol == 1) ? 4 : 8;
  endfunction

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi_decerr_slave_if.sv
// rtl/axi_decerr_slave_if.sv - AXI subset bus seen by the error slave
// Parameters: ID_W, ADDR_W, DATA_W, LEN_W (AxLEN width, 8 or 4)
// Modports:
//   master : drives AW/W/AR payload+valid and B/R ready
//   slave  : drives AW/W/AR ready and B/R payload+valid
interface axi_decerr_slave_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [LEN_W-1:0]  s_axi_arlen;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awvalid,
    output s_axi_wlast, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awvalid,
    input  s_axi_wlast, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_decerr_slave.sv
// rtl/axi_decerr_slave.sv - AXI default slave terminating every burst with a fixed error response
// Ports:
//   aclk          : clock, rising edge
//   areset        : synchronous active-high reset
//   s_axi         : axi_decerr_slave_if.slave (AW/W/B/AR/R channels)
//   wr_err_cnt    : saturating count of accepted writes  (AXI_DECERR_STATS_EN only)
//   rd_err_cnt    : saturating count of accepted reads   (AXI_DECERR_STATS_EN only)
//   last_err_addr : address of the latest AW/AR handshake (AXI_DECERR_STATS_EN only)
// Optional feature macro: AXI_DECERR_STATS_EN
module axi_decerr_slave
  import axi_pkg::*;
#(
  parameter int         C_AXI_ID_WIDTH   = 1,
  parameter int         C_AXI_ADDR_WIDTH = 32,
  parameter int         C_AXI_DATA_WIDTH = 32,
  parameter int         C_AXI_PROTOCOL   = 0,
  parameter logic [1:0] C_RESP           = RESP_DECERR
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_decerr_slave_if.slave     s_axi
`ifdef AXI_DECERR_STATS_EN
  ,
  output logic [15:0]           wr_err_cnt,
  output logic [15:0]           rd_err_cnt,
  output logic [C_AXI_ADDR_WIDTH-1:0] last_err_addr
`endif
);

  localparam int LEN_W = len_w(C_AXI_PROTOCOL);

  // ------------------------------------------------------------------
  // Write channel: every output is a flop; next values come from comb.
  // ------------------------------------------------------------------
  w_state_t                  w_state, w_next;
  logic                      awready_q, awready_d;
  logic                      wready_q,  wready_d;
  logic                      bvalid_q,  bvalid_d;
  logic [C_AXI_ID_WIDTH-1:0] bid_q,     bid_d;
  logic                      aw_hs;

  assign aw_hs = s_axi.s_axi_awvalid && awready_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      w_state   <= w_next;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
    end
  end

  always_comb begin
    w_next    = w_state;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = 1'b0;
    bid_d     = bid_q;
    case (w_state)
      W_IDLE: begin
        // awready is low for the first idle cycle after reset, so the
        // handshake term uses the registered ready, not the state.
        if (aw_hs) begin
          w_next   = W_DATA;
          bid_d    = s_axi.s_axi_awid;
          wready_d = 1'b1;
        end else begin
          awready_d = 1'b1;
        end
      end
      W_DATA: begin
        // awlen is not tracked; wlast alone closes the burst.
        if (s_axi.s_axi_wvalid && wready_q && s_axi.s_axi_wlast) begin
          w_next   = W_RESP;
          bvalid_d = 1'b1;
        end else begin
          wready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi.s_axi_bready) begin
          w_next    = W_IDLE;
          awready_d = 1'b1;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        w_next = W_IDLE;
      end
    endcase
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bid     = bid_q;
  assign s_axi.s_axi_bresp   = C_RESP;

  // ------------------------------------------------------------------
  // Read channel
  // ------------------------------------------------------------------
  r_state_t                  r_state, r_next;
  logic                      arready_q, arready_d;
  logic                      rvalid_q,  rvalid_d;
  logic                      rlast_q,   rlast_d;
  logic [C_AXI_ID_WIDTH-1:0] rid_q,     rid_d;
  logic [LEN_W-1:0]          len_q,     len_d;
  logic [LEN_W-1:0]          cnt_q,     cnt_d;
  logic [LEN_W-1:0]          cnt_inc;
  logic                      ar_hs;

  assign ar_hs   = s_axi.s_axi_arvalid && arready_q;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    r_next    = r_state;
    arready_d = 1'b0;
    rvalid_d  = 1'b0;
    rlast_d   = 1'b0;
    rid_d     = rid_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_next   = R_DATA;
          rid_d    = s_axi.s_axi_arid;
          len_d    = s_axi.s_axi_arlen;
          cnt_d    = '0;
          rvalid_d = 1'b1;
          // rlast is registered, so it is precomputed for the first beat
          rlast_d  = (s_axi.s_axi_arlen == '0);
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi.s_axi_rready) begin
          if (rlast_q) begin
            r_next    = R_IDLE;
            arready_d = 1'b1;
          end else begin
            cnt_d    = cnt_inc;
            rvalid_d = 1'b1;
            rlast_d  = (cnt_inc == len_q);
          end
        end else begin
          rvalid_d = 1'b1;
          rlast_d  = rlast_q;
        end
      end
      default: begin
        r_next = R_IDLE;
      end
    endcase
  end

  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rlast   = rlast_q;
  assign s_axi.s_axi_rid     = rid_q;
  assign s_axi.s_axi_rresp   = C_RESP;
  assign s_axi.s_axi_rdata   = {C_AXI_DATA_WIDTH{1'b0}};

  // ------------------------------------------------------------------
  // Optional decode-miss statistics
  // ------------------------------------------------------------------
`ifdef AXI_DECERR_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_err_cnt    <= '0;
      rd_err_cnt    <= '0;
      last_err_addr <= '0;
    end else begin
      if (aw_hs && (wr_err_cnt != 16'hFFFF)) begin
        wr_err_cnt <= wr_err_cnt + 16'd1;
      end
      if (ar_hs && (rd_err_cnt != 16'hFFFF)) begin
        rd_err_cnt <= rd_err_cnt + 16'd1;
      end
      // read address wins when both channels handshake together
      if (ar_hs) begin
        last_err_addr <= s_axi.s_axi_araddr;
      end else if (aw_hs) begin
        last_err_addr <= s_axi.s_axi_awaddr;
      end
    end
  end
`else
  logic [C_AXI_ADDR_WIDTH-1:0] unused_addr;
  assign unused_addr = s_axi.s_axi_awaddr | s_axi.s_axi_araddr;
`endif

endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb/tb_axi_decerr_slave.sv - scoreboard bench for axi_decerr_slave
module tb_axi_decerr_slave;
  import axi_pkg::*;

  localparam int IDW  = 1;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int PROT = 0;
  localparam int LW   = len_w(PROT);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           last;
  } r_exp_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_decerr_slave_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

`ifdef AXI_DECERR_STATS_EN
  logic [15:0]   wr_err_cnt;
  logic [15:0]   rd_err_cnt;
  logic [AW-1:0] last_err_addr;
`endif

  axi_decerr_slave #(
    .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW),
    .C_AXI_PROTOCOL(PROT), .C_RESP(2'b11)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axi(bus)
`ifdef AXI_DECERR_STATS_EN
    ,
    .wr_err_cnt(wr_err_cnt),
    .rd_err_cnt(rd_err_cnt),
    .last_err_addr(last_err_addr)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [IDW-1:0] exp_b[$];
  r_exp_t         exp_r[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got unexpected event required none", name);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor: checks each B/R handshake against the queued expectation.
  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.s_axi_bvalid && bus.s_axi_bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else begin
          logic [IDW-1:0] eb;
          eb = exp_b.pop_front();
          chk("mon_bid", bus.s_axi_bid, eb);
          chk("mon_bresp", bus.s_axi_bresp, 2'b11);
        end
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          r_exp_t er;
          er = exp_r.pop_front();
          chk("mon_rid", bus.s_axi_rid, er.id);
          chk("mon_rlast", bus.s_axi_rlast, er.last);
          chk("mon_rdata", bus.s_axi_rdata, 0);
          chk("mon_rresp", bus.s_axi_rresp, 2'b11);
        end
      end
    end
  end

  task automatic push_read(input logic [IDW-1:0] id, input int len);
    for (int i = 0; i <= len; i++) begin
      r_exp_t e;
      e.id   = id;
      e.last = (i == len);
      exp_r.push_back(e);
    end
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input int beats,
                          input logic [AW-1:0] addr, input int bstall);
    int t = 0;
    while (!bus.s_axi_awready && t < 50) begin tick(); t++; end
    chk("wr_awready_wait", bus.s_axi_awready, 1);
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_awid    = id;
    bus.s_axi_awaddr  = addr;
    exp_b.push_back(id);
    tick();
    bus.s_axi_awvalid = 1'b0;
    chk("aw_awready_low", bus.s_axi_awready, 0);
    chk("aw_wready_high", bus.s_axi_wready, 1);
    bus.s_axi_bready = (bstall == 0);
    for (int i = 0; i < beats; i++) begin
      bus.s_axi_wvalid = 1'b1;
      bus.s_axi_wlast  = (i == beats - 1);
      tick();
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
    chk("wl_wready_low", bus.s_axi_wready, 0);
    chk("wl_bvalid", bus.s_axi_bvalid, 1);
    chk("wl_bid", bus.s_axi_bid, id);
    for (int s = 0; s < bstall; s++) begin
      tick();
      chk("bstall_bvalid", bus.s_axi_bvalid, 1);
      chk("bstall_bid", bus.s_axi_bid, id);
    end
    bus.s_axi_bready = 1'b1;
    tick();
    chk("b_done_bvalid", bus.s_axi_bvalid, 0);
    chk("b_done_awready", bus.s_axi_awready, 1);
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input int len, input logic [AW-1:0] addr);
    int t = 0;
    while (!bus.s_axi_arready && t < 50) begin tick(); t++; end
    chk("rd_arready_wait", bus.s_axi_arready, 1);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_arid    = id;
    bus.s_axi_arlen   = LW'(len);
    bus.s_axi_araddr  = addr;
    bus.s_axi_rready  = 1'b1;
    push_read(id, len);
    tick();
    bus.s_axi_arvalid = 1'b0;
    chk("ar_arready_low", bus.s_axi_arready, 0);
    chk("ar_rid", bus.s_axi_rid, id);
    for (int i = 0; i <= len; i++) begin
      chk("r_consecutive", bus.s_axi_rvalid, 1);
      tick();
    end
    chk("r_done_rvalid", bus.s_axi_rvalid, 0);
    chk("r_done_arready", bus.s_axi_arready, 1);
  endtask

  initial begin
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;

    // reset values
    repeat (3) tick();
    chk("rst_awready", bus.s_axi_awready, 0);
    chk("rst_arready", bus.s_axi_arready, 0);
    chk("rst_wready", bus.s_axi_wready, 0);
    chk("rst_bvalid", bus.s_axi_bvalid, 0);
    chk("rst_rvalid", bus.s_axi_rvalid, 0);
    chk("rst_rlast", bus.s_axi_rlast, 0);
    chk("rst_bid", bus.s_axi_bid, 0);
    chk("rst_rid", bus.s_axi_rid, 0);
    chk("rst_rdata", bus.s_axi_rdata, 0);
    areset = 1'b0;
    tick();
    chk("post_rst_awready", bus.s_axi_awready, 1);
    chk("post_rst_arready", bus.s_axi_arready, 1);

    // W before AW is held off
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wlast  = 1'b1;
    tick();
    chk("early_w_wready", bus.s_axi_wready, 0);
    tick();
    chk("early_w_wready2", bus.s_axi_wready, 0);
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;

    // 4-beat write id=1
    do_write(1'b1, 4, 32'h0000_0040, 0);

    // 8-beat read id=0
    do_read(1'b0, 7, 32'h0000_0080);

    // simultaneous AW and AR, 1-beat write, arlen=0
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awid = 1'b1; bus.s_axi_awaddr = 32'h10;
    bus.s_axi_arvalid = 1'b1; bus.s_axi_arid = 1'b1; bus.s_axi_arlen = '0;
    bus.s_axi_araddr = 32'h20;
    bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
    exp_b.push_back(1'b1);
    push_read(1'b1, 0);
    tick();
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    chk("sim_awready", bus.s_axi_awready, 0);
    chk("sim_arready", bus.s_axi_arready, 0);
    chk("sim_wready", bus.s_axi_wready, 1);
    chk("sim_rvalid", bus.s_axi_rvalid, 1);
    chk("sim_rlast", bus.s_axi_rlast, 1);
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wlast  = 1'b1;
    tick();
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
    chk("sim_bvalid", bus.s_axi_bvalid, 1);
    chk("sim_r_done", bus.s_axi_rvalid, 0);
    chk("sim_arready_back", bus.s_axi_arready, 1);
    tick();
    chk("sim_b_done", bus.s_axi_bvalid, 0);
    chk("sim_awready_back", bus.s_axi_awready, 1);

    // rready toggling during arlen=3
    begin
      int hs = 0;
      int c  = 0;
      bus.s_axi_arvalid = 1'b1; bus.s_axi_arid = 1'b0; bus.s_axi_arlen = LW'(3);
      bus.s_axi_rready = 1'b0;
      push_read(1'b0, 3);
      tick();
      bus.s_axi_arvalid = 1'b0;
      while (hs < 4 && c < 40) begin
        bus.s_axi_rready = c[0];
        chk("stall_rvalid", bus.s_axi_rvalid, 1);
        chk("stall_rlast", bus.s_axi_rlast, (hs == 3));
        if (bus.s_axi_rvalid && bus.s_axi_rready) hs++;
        tick();
        c++;
      end
      bus.s_axi_rready = 1'b1;
      chk("stall_handshakes", hs, 4);
      chk("stall_done_rvalid", bus.s_axi_rvalid, 0);
    end

    // B backpressure, 2-beat write id=0
    do_write(1'b0, 2, 32'h0000_0044, 3);

    // reset in the middle of a 16-beat read
    bus.s_axi_arvalid = 1'b1; bus.s_axi_arid = 1'b1; bus.s_axi_arlen = LW'(15);
    bus.s_axi_rready = 1'b1;
    push_read(1'b1, 15);
    tick();
    bus.s_axi_arvalid = 1'b0;
    repeat (5) tick();
    chk("mid_rvalid_before", bus.s_axi_rvalid, 1);
    areset = 1'b1;
    tick();
    exp_r.delete();
    chk("mid_rst_rvalid", bus.s_axi_rvalid, 0);
    chk("mid_rst_rlast", bus.s_axi_rlast, 0);
    chk("mid_rst_rid", bus.s_axi_rid, 0);
    chk("mid_rst_arready", bus.s_axi_arready, 0);
    areset = 1'b0;
    tick();
    chk("mid_rel_arready", bus.s_axi_arready, 1);
    chk("mid_rel_awready", bus.s_axi_awready, 1);
    do_read(1'b1, 2, 32'h0000_00C0);

`ifdef AXI_DECERR_STATS_EN
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("st_rst_wr", wr_err_cnt, 0);
    chk("st_rst_rd", rd_err_cnt, 0);
    chk("st_rst_addr", last_err_addr, 0);
    do_write(1'b0, 1, 32'h0000_0100, 0);
    do_write(1'b1, 2, 32'h0000_0200, 0);
    do_write(1'b0, 3, 32'h0000_0300, 0);
    do_read(1'b0, 1, 32'h0000_1000);
    do_read(1'b1, 0, 32'h0000_2000);
    chk("st_wr_cnt", wr_err_cnt, 3);
    chk("st_rd_cnt", rd_err_cnt, 2);
    chk("st_last_addr", last_err_addr, 32'h0000_2000);
`endif

    tick();
    chk("sb_b_drained", exp_b.size(), 0);
    chk("sb_r_drained", exp_r.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_decerr_slave.md
# axi_decerr_slave

AXI4/AXI3 default (error) slave that terminates every transaction routed to it with a fixed error response. It hangs directly off an unused or unmapped master slot of the AXI crossbar, so that decode misses complete protocol-correctly instead of hanging the interconnect. Write and read channels are independent FSMs, each with one transaction outstanding. Bursts are honoured beat-for-beat.

## Interface
- C_AXI_ID_WIDTH, 1, ID width of all ID ports
- C_AXI_ADDR_WIDTH, 32, address width; addresses are used only under the stats option
- C_AXI_DATA_WIDTH, 32, RDATA width
- C_AXI_PROTOCOL, 0, 0 = AXI4 (8-bit len), 1 = AXI3 (4-bit len)
- C_RESP, 2'b11, response code returned on BRESP/RRESP (DECERR)
- aclk  in  1  clock, rising edge
- areset  in  1  synchronous, active-high reset
- s_axi_awid  in  C_AXI_ID_WIDTH  write ID
- s_axi_awaddr  in  C_AXI_ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake; wdata/wstrb/wid are not connected
- s_axi_bid  out  C_AXI_ID_WIDTH  response ID
- s_axi_bresp  out  2  = C_RESP
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_arid  in  C_AXI_ID_WIDTH  read ID
- s_axi_araddr  in  C_AXI_ADDR_WIDTH  read address
- s_axi_arlen  in  8 or 4  burst length minus 1
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rid  out  C_AXI_ID_WIDTH  read ID
- s_axi_rdata  out  C_AXI_DATA_WIDTH  always 0
- s_axi_rresp  out  2  = C_RESP
- s_axi_rlast  out  1  final beat
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake

## Operation
- Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
  - W_IDLE → W_DATA on awvalid&awready; awid is latched into bid.
  - W_DATA sinks beats. It → W_RESP on wvalid&wready&wlast. awlen is ignored; only wlast terminates the burst.
  - W_RESP → W_IDLE on bvalid&bready.
- Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1).
  - R_IDLE → R_DATA on arvalid&arready; arid and arlen are latched, and the beat counter is cleared.
  - In R_DATA, rlast = (cnt == len_q). The counter increments on rvalid&rready.
  - R_DATA → R_IDLE on the rlast handshake.
- The two FSMs run concurrently with no interaction. A simultaneous AW and AR are both accepted in the same cycle.
- W data arriving before AW is held off: wready stays 0 until AW is accepted.
- arlen = 0 produces a single beat with rlast=1. Maximum is 256 beats (AXI4) or 16 beats (AXI3).
- The counter is the same width as len and never wraps within a legal burst.

## Timing
- All outputs are registered.
- Reset values: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0. rdata is 0 at all times.
- awready and arready rise on the first clock after areset deasserts.
- AW handshake at cycle N → awready=0 and wready=1 at N+1.
- Last-W handshake at N → wready=0 and bvalid=1 at N+1.
- B handshake at N → awready=1 at N+1. Write throughput is therefore one beat per cycle plus 2 cycles of overhead.
- AR handshake at N → rvalid=1 at N+1, with rid valid.
- Beats stream back-to-back while rready=1. On the last-beat handshake at N, arready=1 at N+1.
- Backpressure: bvalid, rvalid, rid, bid and rlast hold stable while ready is 0.
- areset mid-transaction: both FSMs return to idle at the next edge, all outputs take their reset values, and the burst is abandoned.

## Configuration
- AXI_DECERR_STATS_EN defined:
  - Adds outputs wr_err_cnt[15:0], rd_err_cnt[15:0] and last_err_addr[C_AXI_ADDR_WIDTH-1:0].
  - Each counter increments on its AW or AR handshake and saturates at 16'hFFFF.
  - last_err_addr captures the address on every AW/AR handshake. If both handshakes occur in the same cycle, the AR address is captured.
  - All three outputs reset to 0.
- AXI_DECERR_STATS_EN undefined: these ports are absent, and the awaddr/araddr inputs are unused.

## Structure
- Shared package axi_pkg holds:
  - response constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR;
  - the len-width function len_w(protocol);
  - the write- and read-FSM state enums.
- No sub-module: both FSMs live in axi_decerr_slave.

## Test plan
- AW id=1, then 4 W beats with wlast on beat 4, bready=1 → bvalid exactly 1 cycle after the last W handshake, bid=1, bresp=2'b11; awready returns 1 cycle later.
- AR id=0, arlen=7, rready=1 → 8 consecutive beats, rdata=0, rresp=2'b11, rlast only on beat 8, rid=0.
- Simultaneous AW and AR in the same cycle with a 1-beat write and arlen=0 → both accepted together; B and a single R beat with rlast=1 both complete.
- rready toggled 1/0 every cycle during arlen=3 → rvalid and rlast stable while stalled; exactly 4 handshakes occur.
- areset pulsed in the middle of an arlen=15 read → next cycle rvalid=0; arready=1 one cycle after reset release; a new read completes correctly.
- With AXI_DECERR_STATS_EN, 3 writes and 2 reads → wr_err_cnt=3, rd_err_cnt=2, last_err_addr equals the final handshake's address.
